// File: rtl/clock_comp_rx.sv
// rtl/clock_comp_rx.sv - 100GbE PCS receive rate compensator (AM removal, IPG idle insertion)
//
// Purpose: sits after lane deskew/reorder. Alignment-marker blocks flagged by
// i_am_tag are never stored. Every qualifying input cycle (i_enable && i_valid)
// still yields exactly one registered output block. The FIFO sits at FILL_LEVEL
// in steady state. Each dropped AM lowers it by one. Idles are inserted only
// while the emitted stream is in an inter-packet gap, which refills the FIFO.
//
// Ports:
//   i_clock      system clock
//   i_reset      asynchronous active-high reset
//   i_enable     block enable; low freezes all state and suppresses o_valid
//   i_valid      input block strobe
//   i_data       66b received block ([65:64] sync, [63:56] block type)
//   i_am_tag     high: i_data is an alignment marker and is discarded
//   o_data       compensated block
//   o_valid      o_data updated this cycle (one cycle after a qualifying input)
//   o_occupancy  FIFO occupancy, 0..FIFO_DEPTH
//   o_underflow  sticky: an ERROR block was emitted because the FIFO ran dry mid-frame
module clock_comp_rx #(
  parameter int NB_DATA_CODED = 66,
  parameter int N_LANES       = 20,
  parameter int FIFO_DEPTH    = 32,
  parameter int NB_ADDR       = 5,
  parameter int FILL_LEVEL    = 24
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic                     i_valid,
  input  logic [NB_DATA_CODED-1:0] i_data,
  input  logic                     i_am_tag,
  output logic [NB_DATA_CODED-1:0] o_data,
  output logic                     o_valid,
  output logic [NB_ADDR:0]         o_occupancy,
  output logic                     o_underflow
);

  // The target fill must hold a full AM period of removed markers.
  if (NB_DATA_CODED != 66 || FILL_LEVEL < N_LANES || FIFO_DEPTH <= FILL_LEVEL ||
      FIFO_DEPTH != (1 << NB_ADDR)) begin : g_cfg_check
    $error("clock_comp_rx: inconsistent parameters");
  end

  localparam logic [NB_DATA_CODED-1:0] IDLE_BLK  = {2'b10, 8'h1E, 56'h0};
  localparam logic [NB_DATA_CODED-1:0] ERROR_BLK = {2'b10, 8'h1E, {8{7'h1E}}};
  localparam logic [NB_ADDR:0]         FILL      = (NB_ADDR + 1)'(FILL_LEVEL);

  typedef enum logic {INIT_FILL, RUN} state_t;

  state_t                   state, state_next;
  logic [NB_DATA_CODED-1:0] mem [FIFO_DEPTH];
  logic [NB_ADDR-1:0]       wr_ptr, rd_ptr;
  logic [NB_ADDR:0]         occ;
  logic                     in_ipg, in_ipg_next;
  logic                     qv, wr_en, rd_en, emit_err;
  logic [NB_DATA_CODED-1:0] emit_blk;

  assign qv          = i_enable && i_valid;
  assign wr_en       = qv && !i_am_tag;
  assign o_occupancy = occ;

  // Decision uses occupancy before this cycle's write, so a block written into
  // an empty FIFO is never bypassed straight to the output.
  always_comb begin
    state_next = state;
    rd_en      = 1'b0;
    emit_err   = 1'b0;
    emit_blk   = IDLE_BLK;
    case (state)
      INIT_FILL: begin
        if (qv && (occ + {{NB_ADDR{1'b0}}, wr_en}) >= FILL) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (occ < FILL && in_ipg) begin
          emit_blk = IDLE_BLK;
        end else if (occ != '0) begin
          rd_en    = qv;
          emit_blk = mem[rd_ptr];
        end else begin
          emit_blk = ERROR_BLK;
          emit_err = qv;
        end
      end
      default: state_next = INIT_FILL;
    endcase
  end

  // Gap tracking follows what leaves the block, so insertion can never split a
  // frame: it is cleared by a start and only set again by a terminate or idle.
  always_comb begin
    in_ipg_next = in_ipg;
    if (emit_blk == IDLE_BLK) begin
      in_ipg_next = 1'b1;
    end else if (emit_blk[65:64] == 2'b10) begin
      case (emit_blk[63:56])
        8'h78:                                            in_ipg_next = 1'b0;
        8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF: in_ipg_next = 1'b1;
        default:                                          in_ipg_next = in_ipg;
      endcase
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state       <= INIT_FILL;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      in_ipg      <= 1'b1;
      o_data      <= IDLE_BLK;
      o_valid     <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      o_valid <= qv;
      if (qv) begin
        state  <= state_next;
        o_data <= emit_blk;
        in_ipg <= in_ipg_next;
        if (wr_en) wr_ptr <= wr_ptr + 1'b1;
        if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        case ({wr_en, rd_en})
          2'b10:   occ <= occ + 1'b1;
          2'b01:   occ <= occ - 1'b1;
          default: occ <= occ;
        endcase
        if (emit_err) o_underflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (wr_en) mem[wr_ptr] <= i_data;
  end

endmodule

// File: tb/tb_clock_comp_rx.sv
// tb/tb_clock_comp_rx.sv - scoreboard bench for clock_comp_rx
module tb_clock_comp_rx;
  localparam int FILL = 24;
  localparam logic [65:0] IDLE = {2'b10, 8'h1E, 56'h0};
  localparam logic [65:0] ERR  = {2'b10, 8'h1E, {8{7'h1E}}};
  localparam logic [65:0] AMB  = {2'b10, 64'hC168_21F4_3E97_DE0B};
  localparam logic [65:0] SOF  = {2'b10, 8'h78, 56'h55_5555_5555_5555};
  localparam logic [65:0] EOF  = {2'b10, 8'h87, 56'h0};

  typedef struct packed {
    logic [65:0] d;
    logic [5:0]  occ;
    logic        uf;
  } exp_t;

  logic        clk = 1'b0, rst = 1'b1, en = 1'b0, vld = 1'b0, am = 1'b0;
  logic [65:0] din = IDLE;
  logic [65:0] o_data;
  logic        o_valid, o_uf;
  logic [5:0]  o_occ;

  int total = 0, bad = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [65:0] mq[$];
  logic [65:0] log_d[$];
  int          log_o[$];
  bit          m_run = 0, m_ipg = 1, m_uf = 0;

  clock_comp_rx dut (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_valid(vld),
    .i_data(din), .i_am_tag(am),
    .o_data(o_data), .o_valid(o_valid), .o_occupancy(o_occ), .o_underflow(o_uf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [65:0] dblk(input int i);
    return {2'b01, 32'hDA7A_0000, 32'(i)};
  endfunction

  function automatic bit is_term(input logic [7:0] t);
    return t inside {8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
  endfunction

  // Reference behaviour kept as a queue of stored blocks plus frame/fill flags.
  task automatic model_step(input logic [65:0] d, input logic is_am);
    logic [65:0] e;
    exp_t x;
    int occ;
    occ = mq.size();
    if (!m_run) begin
      e = IDLE;
      if (occ + (is_am ? 0 : 1) >= FILL) m_run = 1;
    end else if (occ < FILL && m_ipg) begin
      e = IDLE;
    end else if (occ > 0) begin
      e = mq.pop_front();
    end else begin
      e = ERR;
      m_uf = 1;
    end
    if (!is_am) mq.push_back(d);
    if (e == IDLE) m_ipg = 1;
    else if (e[65:64] == 2'b10 && e[63:56] == 8'h78) m_ipg = 0;
    else if (e[65:64] == 2'b10 && is_term(e[63:56])) m_ipg = 1;
    x.d = e;
    x.occ = 6'(mq.size());
    x.uf = m_uf;
    exp_q.push_back(x);
  endtask

  task automatic send(input logic [65:0] d, input logic is_am);
    @(posedge clk); #1;
    en = 1'b1; vld = 1'b1; din = d; am = is_am;
    model_step(d, is_am);
  endtask

  task automatic drain();
    @(posedge clk); #1;
    vld = 1'b0; am = 1'b0;
    @(negedge clk); #1;
  endtask

  function automatic int count_eq(input int lo, input int hi, input logic [65:0] v);
    int n = 0;
    for (int i = lo; i <= hi && i < log_d.size(); i++) if (log_d[i] == v) n++;
    return n;
  endfunction

  // Monitor: compares every presented output against the scoreboard.
  always @(negedge clk) begin
    if (o_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got %h with empty scoreboard", o_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("o_data", o_data, mon_e.d);
        chk("o_occupancy", 66'(o_occ), 66'(mon_e.occ));
        chk("o_underflow", 66'(o_uf), 66'(mon_e.uf));
      end
      chk("am_leak", 66'(o_data == AMB), 66'(0));
      log_d.push_back(o_data);
      log_o.push_back(int'(o_occ));
    end
    if (!rst) chk("occ_bound", 66'(o_occ > 6'(FILL)), 66'(0));
  end

  task automatic frame_check(input string nm, input int base, output int s, output int t);
    s = -1;
    t = -1;
    for (int i = base; i < log_d.size(); i++) begin
      if (s < 0 && log_d[i] == SOF) s = i;
      if (s >= 0 && t < 0 && log_d[i] == EOF) t = i;
    end
    chk({nm, "_found"}, 66'(s >= 0 && t > s && t + 20 < log_d.size()), 66'(1));
    if (s >= 0 && t > s) chk({nm, "_idle_in_frame"}, 66'(count_eq(s, t, IDLE)), 66'(0));
  endtask

  initial begin
    int base, s, t;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_valid", 66'(o_valid), 66'(0));
    chk("rst_occ", 66'(o_occ), 66'(0));
    chk("rst_data", o_data, IDLE);
    chk("rst_uf", 66'(o_uf), 66'(0));
    rst = 1'b0;

    // 1: initial fill with idle traffic
    for (int i = 0; i < 40; i++) send(IDLE, 1'b0);
    drain();
    chk("t1_occ", 66'(o_occ), 66'(24));
    chk("t1_init_idles", 66'(count_eq(0, 23, IDLE)), 66'(24));

    // 2: a burst of markers inside idle traffic
    base = log_d.size();
    for (int i = 0; i < 20; i++) send(AMB, 1'b1);
    for (int i = 0; i < 30; i++) send(IDLE, 1'b0);
    drain();
    chk("t2_count", 66'(log_d.size() - base), 66'(50));
    chk("t2_all_idle", 66'(count_eq(base, log_d.size() - 1, IDLE)), 66'(50));
    chk("t2_occ", 66'(o_occ), 66'(24));

    // 3: 100-block frame carrying 20 markers
    base = log_d.size();
    for (int i = 0; i < 100; i++) begin
      send(i == 0 ? SOF : (i == 99 ? EOF : dblk(i)), 1'b0);
      if (i >= 30 && i <= 87 && (i - 30) % 3 == 0) send(AMB, 1'b1);
    end
    for (int i = 0; i < 60; i++) send(IDLE, 1'b0);
    drain();
    frame_check("t3", base, s, t);
    if (t > 0 && t + 20 < log_d.size()) begin
      chk("t3_occ_at_term", 66'(log_o[t]), 66'(4));
      chk("t3_idles_after", 66'(count_eq(t + 1, t + 20, IDLE)), 66'(20));
      chk("t3_occ_refilled", 66'(log_o[t + 20]), 66'(24));
    end
    chk("t3_uf", 66'(o_uf), 66'(0));

    // 4: 300-block frame with 30 markers runs the FIFO dry
    base = log_d.size();
    for (int i = 0; i < 300; i++) begin
      send(i == 0 ? SOF : (i == 299 ? EOF : dblk(1000 + i)), 1'b0);
      if (i >= 30 && i <= 175 && (i - 30) % 5 == 0) send(AMB, 1'b1);
    end
    for (int i = 0; i < 60; i++) send(IDLE, 1'b0);
    drain();
    frame_check("t4", base, s, t);
    chk("t4_errors", 66'(count_eq(base, log_d.size() - 1, ERR)), 66'(7));
    chk("t4_uf", 66'(o_uf), 66'(1));
    chk("t4_occ", 66'(o_occ), 66'(24));

    // 6: enable low mid-frame with valid held high
    send(SOF, 1'b0);
    for (int i = 0; i < 40; i++) send(dblk(2000 + i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i > 0) begin
        chk("t6_valid", 66'(o_valid), 66'(0));
        chk("t6_occ", 66'(o_occ), 66'(24));
      end
      en = 1'b0; vld = 1'b1; din = dblk(999); am = 1'b0;
    end
    for (int i = 0; i < 20; i++) send(dblk(2040 + i), 1'b0);
    send(EOF, 1'b0);
    for (int i = 0; i < 40; i++) send(IDLE, 1'b0);
    drain();
    chk("t6_uf_sticky", 66'(o_uf), 66'(1));

    // 5: asynchronous reset mid-frame
    send(SOF, 1'b0);
    for (int i = 0; i < 10; i++) send(dblk(3000 + i), 1'b0);
    drain();
    #2 rst = 1'b1;
    #1;
    chk("t5_valid", 66'(o_valid), 66'(0));
    chk("t5_occ", 66'(o_occ), 66'(0));
    chk("t5_data", o_data, IDLE);
    chk("t5_uf", 66'(o_uf), 66'(0));
    mq.delete();
    exp_q.delete();
    m_run = 0; m_ipg = 1; m_uf = 0;
    @(posedge clk); #2 rst = 1'b0;
    base = log_d.size();
    for (int i = 0; i < 40; i++) send(dblk(500 + i), 1'b0);
    drain();
    if (log_d.size() > base + 24) begin
      chk("t5_refill_idle", log_d[base + 23], IDLE);
      chk("t5_latency", log_d[base + 24], dblk(500));
    end else begin
      chk("t5_out_count", 66'(log_d.size() - base), 66'(40));
    end
    chk("t5_occ_after", 66'(o_occ), 66'(24));

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 66'(exp_q.size()), 66'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
